// File: rtl/gcd_seq_pkg.sv
// Shared types and constants for the GCD job sequencer.
package gcd_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_WR_AHI,
    S_WR_ALO,
    S_WR_BHI,
    S_WR_BLO,
    S_WAIT,
    S_READ,
    S_DRAIN,
    S_OUT
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_ZERO    = 2'd1,
    ST_TIMEOUT = 2'd2
  } status_t;

  localparam int GCD_DONE_BIT = 0;

endpackage

// File: rtl/gcd_job_sequencer.sv
// Avalon-MM style master feeding the sequential 64-bit GCD peripheral from an
// operand stream and returning results (with status) on a result stream.
module gcd_job_sequencer
  import gcd_seq_pkg::*;
#(
  parameter int unsigned           TIMEOUT_W     = 32,
  parameter logic [TIMEOUT_W-1:0]  TIMEOUT_LIMIT = 32'hFFFF_FFFF
) (
  input  logic        csi_clk,
  input  logic        rsi_reset_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  output logic        gcd_a_hi_write,
  output logic        gcd_a_lo_write,
  output logic        gcd_b_hi_write,
  output logic        gcd_b_lo_write,
  output logic [31:0] gcd_wdata,
  output logic        gcd_result_read,
  input  logic [63:0] gcd_result,
  input  logic [7:0]  gcd_done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_data,
  output logic [1:0]  res_status,
  output logic [15:0] job_count
);

  state_t               state;
  state_t               ret;
  logic                 ready_q;
  logic [31:0]          a_lo_q;
  logic [63:0]          b_q;
  logic [TIMEOUT_W-1:0] wdog;
  logic                 done_bit;
  logic                 unused_done;

  assign done_bit    = gcd_done[GCD_DONE_BIT];
  assign unused_done = ^gcd_done;

  // A stale done seen in IDLE must block acceptance in the same cycle, so the
  // registered ready is qualified combinationally by the live done bit.
  assign op_ready = ready_q & ~done_bit;

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      state           <= S_IDLE;
      ret             <= S_IDLE;
      ready_q         <= 1'b0;
      a_lo_q          <= '0;
      b_q             <= '0;
      wdog            <= '0;
      gcd_a_hi_write  <= 1'b0;
      gcd_a_lo_write  <= 1'b0;
      gcd_b_hi_write  <= 1'b0;
      gcd_b_lo_write  <= 1'b0;
      gcd_wdata       <= '0;
      gcd_result_read <= 1'b0;
      res_valid       <= 1'b0;
      res_data        <= '0;
      res_status      <= ST_OK;
      job_count       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (done_bit) begin
            ready_q         <= 1'b0;
            gcd_result_read <= 1'b1;
            state           <= S_CLEAR;
          end else if (op_valid && op_ready) begin
            ready_q <= 1'b0;
            a_lo_q  <= op_a[31:0];
            b_q     <= op_b;
            // A zero operand would never terminate in the GCD core.
            if (op_a == '0 || op_b == '0) begin
              res_data   <= '0;
              res_status <= ST_ZERO;
              res_valid  <= 1'b1;
              state      <= S_OUT;
            end else begin
              gcd_a_hi_write <= 1'b1;
              gcd_wdata      <= op_a[63:32];
              state          <= S_WR_AHI;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          gcd_result_read <= 1'b0;
          ret             <= S_IDLE;
          state           <= S_DRAIN;
        end
        S_WR_AHI: begin
          gcd_a_hi_write <= 1'b0;
          gcd_a_lo_write <= 1'b1;
          gcd_wdata      <= a_lo_q;
          state          <= S_WR_ALO;
        end
        S_WR_ALO: begin
          gcd_a_lo_write <= 1'b0;
          gcd_b_hi_write <= 1'b1;
          gcd_wdata      <= b_q[63:32];
          state          <= S_WR_BHI;
        end
        S_WR_BHI: begin
          gcd_b_hi_write <= 1'b0;
          gcd_b_lo_write <= 1'b1;
          gcd_wdata      <= b_q[31:0];
          state          <= S_WR_BLO;
        end
        S_WR_BLO: begin
          gcd_b_lo_write <= 1'b0;
          gcd_wdata      <= '0;
          wdog           <= '0;
          state          <= S_WAIT;
        end
        S_WAIT: begin
          if (done_bit) begin
            res_data        <= gcd_result;
            res_status      <= ST_OK;
            gcd_result_read <= 1'b1;
            state           <= S_READ;
          end else if (TIMEOUT_LIMIT != '0 && wdog == TIMEOUT_LIMIT) begin
            res_data   <= '0;
            res_status <= ST_TIMEOUT;
            res_valid  <= 1'b1;
            state      <= S_OUT;
          end else begin
            wdog <= wdog + TIMEOUT_W'(1);
          end
        end
        S_READ: begin
          gcd_result_read <= 1'b0;
          ret             <= S_OUT;
          state           <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!done_bit) begin
            state <= ret;
            if (ret == S_OUT) res_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_count <= job_count + 16'd1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Bench for gcd_job_sequencer with a behavioural subtract-style GCD peripheral.
module tb_gcd_job_sequencer;

  logic        clk;
  logic        rsi_reset_n;
  logic        op_valid;
  logic        op_ready;
  logic [63:0] op_a, op_b;
  logic        a_hi_w, a_lo_w, b_hi_w, b_lo_w;
  logic [31:0] wdata;
  logic        rd;
  logic [63:0] gcd_result;
  logic [7:0]  gcd_done;
  logic        res_valid, res_ready;
  logic [63:0] res_data;
  logic [1:0]  res_status;
  logic [15:0] job_count;

  gcd_job_sequencer #(.TIMEOUT_LIMIT(32'd16)) dut (
    .csi_clk(clk), .rsi_reset_n(rsi_reset_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .gcd_a_hi_write(a_hi_w), .gcd_a_lo_write(a_lo_w),
    .gcd_b_hi_write(b_hi_w), .gcd_b_lo_write(b_lo_w),
    .gcd_wdata(wdata), .gcd_result_read(rd),
    .gcd_result(gcd_result), .gcd_done(gcd_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_status(res_status), .job_count(job_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural GCD peripheral: one subtraction per clock, done when equal.
  logic [63:0] ma = '0, mb = '0, mres = '0;
  logic        mdone = 1'b0, mbusy = 1'b0;
  logic        hang = 1'b0, rel = 1'b0;
  assign gcd_result = mres;
  assign gcd_done   = {7'h2A, mdone};

  always @(posedge clk) begin
    if (a_hi_w) ma[63:32] <= wdata;
    if (a_lo_w) ma[31:0]  <= wdata;
    if (b_hi_w) mb[63:32] <= wdata;
    if (b_lo_w) begin mb[31:0] <= wdata; mbusy <= 1'b1; end
    if (rel) begin
      mdone <= 1'b1; mbusy <= 1'b0; mres <= 64'hDEAD_BEEF;
    end else if (mbusy && !hang && !(a_hi_w | a_lo_w | b_hi_w | b_lo_w)) begin
      if (ma == mb) begin mdone <= 1'b1; mres <= ma; mbusy <= 1'b0; end
      else if (ma > mb) ma <= ma - mb;
      else mb <= mb - ma;
    end
    if (rd) mdone <= 1'b0;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [63:0] data; logic [1:0] status; } exp_t;
  exp_t        sb[$];
  logic [1:0]  log_kind[$];
  logic [31:0] log_data[$];
  int          reads = 0;
  int          viol = 0;

  // Result scoreboard and write-bus rule monitor.
  always @(negedge clk) begin
    int n;
    exp_t e;
    if (rsi_reset_n && res_valid && res_ready) begin
      if (sb.size() == 0) check("sb_unexpected_result", res_data, 64'hX);
      else begin
        e = sb.pop_front();
        check("res_data", res_data, e.data);
        check("res_status", 64'(res_status), 64'(e.status));
      end
    end
    n = int'(a_hi_w) + int'(a_lo_w) + int'(b_hi_w) + int'(b_lo_w);
    if (n > 1 || (n > 0 && rd)) viol++;
    if (n == 0 && wdata != 32'd0) viol++;
    if (n == 1) begin
      log_kind.push_back(a_hi_w ? 2'd0 : a_lo_w ? 2'd1 : b_hi_w ? 2'd2 : 2'd3);
      log_data.push_back(wdata);
    end
    if (rd) reads++;
  end

  logic [15:0] exp_cnt = '0;

  task automatic wait_ready();
    int w = 0;
    while (!op_ready && w < 100) begin @(posedge clk); #1; w++; end
    check("op_ready_wait", 64'(op_ready), 64'd1);
  endtask

  task automatic run_job(input logic [63:0] a, input logic [63:0] b, input logic [63:0] d,
                         input logic [1:0] st, input int lat, input int hold);
    int l;
    int stab;
    int r0;
    logic [31:0] ew[4];
    log_kind.delete(); log_data.delete();
    r0 = reads;
    wait_ready();
    op_a = a; op_b = b; op_valid = 1'b1;
    sb.push_back('{d, st});
    if (hold > 0) res_ready = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    l = 0;
    do begin @(negedge clk); l++; end while (!res_valid && l < 200);
    check("res_valid_seen", 64'(res_valid), 64'd1);
    if (lat > 0) check("latency", 64'(l), 64'(lat));
    if (hold > 0) begin
      stab = 0;
      repeat (hold) begin
        @(negedge clk);
        if (!res_valid || res_data !== d || res_status !== st || op_ready || job_count !== exp_cnt)
          stab++;
      end
      check("backpressure_hold", 64'(stab), 64'd0);
      @(posedge clk); #1;
      res_ready = 1'b1;
      @(negedge clk);
    end
    exp_cnt++;
    @(negedge clk);
    check("job_count", 64'(job_count), 64'(exp_cnt));
    check("res_valid_drop", 64'(res_valid), 64'd0);
    ew[0] = a[63:32]; ew[1] = a[31:0]; ew[2] = b[63:32]; ew[3] = b[31:0];
    if (st == 2'd1) check("zero_no_writes", 64'(log_kind.size()), 64'd0);
    else begin
      check("write_count", 64'(log_kind.size()), 64'd4);
      for (int i = 0; i < 4 && i < log_kind.size(); i++) begin
        check("write_order", 64'(log_kind[i]), 64'(i));
        check("write_data", 64'(log_data[i]), 64'(ew[i]));
      end
    end
    check("read_pulses", 64'(reads - r0), (st == 2'd0) ? 64'd1 : 64'd0);
  endtask

  task automatic expect_clear(input string name);
    int r0;
    int w;
    int bad;
    r0 = reads; w = 0; bad = 0;
    while (w < 50) begin
      @(negedge clk);
      if (op_ready && gcd_done[0]) bad++;
      if (op_ready) break;
      w++;
    end
    check({name, "_read_pulse"}, 64'(reads - r0), 64'd1);
    check({name, "_op_ready"}, 64'(op_ready), 64'd1);
    check({name, "_ready_vs_done"}, 64'(bad), 64'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctrl"}, 64'({op_ready, a_hi_w, a_lo_w, b_hi_w, b_lo_w, rd, res_valid, res_status}), 64'd0);
    check({name, "_wdata"}, 64'(wdata), 64'd0);
    check({name, "_res_data"}, res_data, 64'd0);
    check({name, "_job_count"}, 64'(job_count), 64'd0);
  endtask

  typedef struct { logic [63:0] a, b, gcd; logic [1:0] st; int lat; } vec_t;
  vec_t vt[6];

  initial begin
    vt[0] = '{64'd5, 64'd5, 64'd5, 2'd0, 9};
    vt[1] = '{64'd12, 64'd18, 64'd6, 2'd0, 11};
    vt[2] = '{64'h1_0000_0000, 64'h8000_0000, 64'h8000_0000, 2'd0, 10};
    vt[3] = '{64'd0, 64'd7, 64'd0, 2'd1, 1};
    vt[4] = '{64'd100, 64'd75, 64'd25, 2'd0, 12};
    vt[5] = '{64'd9, 64'd0, 64'd0, 2'd1, 1};

    rsi_reset_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rsi_reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_job(vt[i].a, vt[i].b, vt[i].gcd, vt[i].st, vt[i].lat, 0);

    // Result held under backpressure.
    run_job(64'd12, 64'd18, 64'd6, 2'd0, 11, 20);

    // Watchdog abort, then a late done is flushed before accepting again.
    hang = 1'b1;
    run_job(64'd9, 64'd6, 64'd0, 2'd2, 0, 0);
    repeat (2) @(posedge clk);
    #1 check("ready_after_timeout", 64'(op_ready), 64'd1);
    rel = 1'b1;
    @(posedge clk); #1;
    rel = 1'b0; hang = 1'b0;
    expect_clear("late_done");
    run_job(64'd21, 64'd14, 64'd7, 2'd0, 11, 0);

    // Reset in WAIT while done is pending.
    hang = 1'b1;
    wait_ready();
    op_a = 64'd10; op_b = 64'd4; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rel = 1'b1;
    @(posedge clk); #1;
    rel = 1'b0;
    @(negedge clk);
    rsi_reset_n = 1'b0;
    #1 check_zero("async_reset");
    exp_cnt = '0;
    @(posedge clk); #1;
    rsi_reset_n = 1'b1; hang = 1'b0;
    expect_clear("post_reset");
    check("post_reset_job_count", 64'(job_count), 64'd0);
    run_job(vt[1].a, vt[1].b, vt[1].gcd, vt[1].st, vt[1].lat, 0);

    check("write_bus_rules", 64'(viol), 64'd0);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule
